// File: rtl/mux4way16_arbiter_pkg.sv
// Shared definitions for the four-requester round-robin arbiter:
// FSM encodings, requester indices and the round-robin pick function.
package mux4way16_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [1:0] IDX_A = 2'd0;
    localparam logic [1:0] IDX_B = 2'd1;
    localparam logic [1:0] IDX_C = 2'd2;
    localparam logic [1:0] IDX_D = 2'd3;

    // Scans from the farthest offset down to ptr, so the last hit is the nearest set bit.
    // The result is meaningless when req is all-zero; callers gate on |req.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        rr_pick = ptr;
        for (int unsigned k = 0; k < 4; k++) begin
            idx = ptr + 2'(3 - k);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

endpackage

// File: rtl/mux4way16_arbiter_mux.sv
// Four-way 16-bit word multiplexer used as the arbiter's shared datapath.
module Mux4Way16
    import mux4way16_arbiter_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [15:0] c,
    input  logic [15:0] d,
    input  logic [1:0]  sel,
    output logic [15:0] out
);

    always_comb begin
        out = a;
        case (sel)
            IDX_A:   out = a;
            IDX_B:   out = b;
            IDX_C:   out = c;
            IDX_D:   out = d;
            default: out = a;
        endcase
    end

endmodule

// File: rtl/mux4way16_arbiter.sv
// Round-robin arbiter granting one of four requesters a shared 16-bit
// valid/ready output for a burst of up to MAX_BEATS transfers.
module mux4way16_arbiter
    import mux4way16_arbiter_pkg::*;
#(
    parameter int unsigned MAX_BEATS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [3:0]  last,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [15:0] c,
    input  logic [15:0] d,
    output logic [15:0] out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  grant,
    output logic [1:0]  sel
);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] ptr;
    logic [1:0] pick;
    logic [3:0] cnt;
    logic [3:0] cnt_inc;
    logic       xfer;
    logic       rel;

    always_comb begin
        pick    = rr_pick(req, ptr);
        cnt_inc = cnt + 4'd1;
        xfer    = (state == BUSY) && req[sel] && out_ready;
        rel     = (state == BUSY) &&
                  (!req[sel] || (xfer && (last[sel] || (cnt_inc == 4'(MAX_BEATS)))));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req) state_nxt = BUSY;
            BUSY:    if (rel)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state == BUSY) && req[sel];
    end

    // Count is reloaded on every new grant, so it is left untouched on the release edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel   <= '0;
            grant <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        sel   <= pick;
                        grant <= 4'b0001 << pick;
                        cnt   <= '0;
                    end
                end
                BUSY: begin
                    if (rel) begin
                        ptr   <= sel + 2'd1;
                        grant <= '0;
                    end else if (xfer) begin
                        cnt <= cnt_inc;
                    end
                end
                default: grant <= '0;
            endcase
        end
    end

    Mux4Way16 u_mux (
        .a   (a),
        .b   (b),
        .c   (c),
        .d   (d),
        .sel (sel),
        .out (out)
    );

endmodule

// File: tb/tb_mux4way16_arbiter.sv
// Scoreboard bench for mux4way16_arbiter: directed scenarios push expected
// beats, per-instance monitors pop and compare on each accepted beat.
module tb_mux4way16_arbiter;

    localparam logic [15:0] WA = 16'hA001;
    localparam logic [15:0] WB = 16'hB002;
    localparam logic [15:0] WC = 16'hC003;
    localparam logic [15:0] WD = 16'hD004;

    typedef struct {
        logic [3:0]  g;
        logic [15:0] d;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] a = WA, b = WB, c = WC, d = WD;

    logic [3:0]  req = '0, last = '0, grant;
    logic        out_ready = 1'b0, out_valid;
    logic [15:0] out;
    logic [1:0]  sel;

    logic [3:0]  req1 = '0, last1 = '0, grant1;
    logic        out_ready1 = 1'b0, out_valid1;
    logic [15:0] out1;
    logic [1:0]  sel1;

    beat_t q[$];
    beat_t q1[$];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mux4way16_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req(req), .last(last),
        .a(a), .b(b), .c(c), .d(d),
        .out(out), .out_valid(out_valid), .out_ready(out_ready),
        .grant(grant), .sel(sel)
    );

    mux4way16_arbiter #(.MAX_BEATS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .last(last1),
        .a(a), .b(b), .c(c), .d(d),
        .out(out1), .out_valid(out_valid1), .out_ready(out_ready1),
        .grant(grant1), .sel(sel1)
    );

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL beat_unexpected grant=%b out=%h required=no_beat", grant, out);
            end else begin
                beat_t e;
                e = q.pop_front();
                if (grant !== e.g || out !== e.d) begin
                    bad++;
                    $display("FAIL beat grant=%b out=%h required grant=%b out=%h", grant, out, e.g, e.d);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid1 && out_ready1) begin
            total++;
            if (q1.size() == 0) begin
                bad++;
                $display("FAIL beat1_unexpected grant=%b out=%h required=no_beat", grant1, out1);
            end else begin
                beat_t e;
                e = q1.pop_front();
                if (grant1 !== e.g || out1 !== e.d) begin
                    bad++;
                    $display("FAIL beat1 grant=%b out=%h required grant=%b out=%h", grant1, out1, e.g, e.d);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req = '0; last = '0; out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] exp2 [10];
        logic [3:0] exp6 [6];
        exp2 = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                 4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};
        exp6 = '{4'b0001, 4'b0000, 4'b0100, 4'b0000, 4'b0001, 4'b0000};

        // asynchronous reset, before any clock edge
        #2 rst_n = 1'b0;
        #1;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_out", 32'(out), 32'(WA));
        @(posedge clk); #1;
        rst_n = 1'b1;

        // single requester b, full MAX_BEATS burst, then ptr=2
        do_reset();
        req = 4'b0010; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) q.push_back('{4'b0010, WB});
        tick();
        chk("s1_grant", 32'(grant), 32'b0010);
        chk("s1_out", 32'(out), 32'(WB));
        repeat (3) tick();
        chk("s1_held", 32'(grant), 32'b0010);
        tick();
        chk("s1_release", 32'(grant), 32'h0);
        chk("s1_idle_out", 32'(out), 32'(WB));
        req = 4'b0101;
        tick();
        chk("s1_ptr2_pick", 32'(grant), 32'b0100);
        req = '0;
        tick();
        chk("s1_abandon", 32'(grant), 32'h0);

        // all requesting with last: rotation with one bubble between grants
        do_reset();
        req = 4'b1111; last = 4'b1111; out_ready = 1'b1;
        q.push_back('{4'b0001, WA});
        q.push_back('{4'b0010, WB});
        q.push_back('{4'b0100, WC});
        q.push_back('{4'b1000, WD});
        q.push_back('{4'b0001, WA});
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("s2_grant%0d", i), 32'(grant), 32'(exp2[i]));
        end
        req = '0; last = '0;

        // owner c stalled by out_ready=0, count must not advance
        do_reset();
        req = 4'b0100;
        tick();
        chk("s3_grant", 32'(grant), 32'b0100);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk($sformatf("s3_hold%0d", i), {27'(grant), 4'b0, 1'(out_valid)}, {27'b0100, 4'b0, 1'b1});
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) q.push_back('{4'b0100, WC});
        repeat (3) tick();
        chk("s3_still", 32'(grant), 32'b0100);
        tick();
        chk("s3_release", 32'(grant), 32'h0);
        req = '0; out_ready = 1'b0;

        // owner d abandons after 2 beats, ptr wraps to 0
        do_reset();
        req = 4'b1000; out_ready = 1'b1;
        q.push_back('{4'b1000, WD});
        q.push_back('{4'b1000, WD});
        tick();
        chk("s4_grant", 32'(grant), 32'b1000);
        repeat (2) tick();
        chk("s4_two_beats", 32'(grant), 32'b1000);
        req = '0;
        tick();
        chk("s4_abandon", 32'(grant), 32'h0);
        req = 4'b1001;
        tick();
        chk("s4_wrap_pick", 32'(grant), 32'b0001);
        req = '0;
        tick();
        chk("s4_idle", 32'(grant), 32'h0);

        // reset mid-burst, next arbitration from index 0
        do_reset();
        req = 4'b0001; out_ready = 1'b1;
        q.push_back('{4'b0001, WA});
        q.push_back('{4'b0001, WA});
        tick();
        chk("s5_grant", 32'(grant), 32'b0001);
        repeat (2) tick();
        #1 rst_n = 1'b0;
        #1;
        chk("s5_async_grant", 32'(grant), 32'h0);
        chk("s5_async_valid", 32'(out_valid), 32'h0);
        chk("s5_async_out", 32'(out), 32'(WA));
        req = 4'b0011;
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        chk("s5_regrant", 32'(grant), 32'b0001);
        req = '0;
        tick();
        chk("s5_idle", 32'(grant), 32'h0);
        out_ready = 1'b0;

        // MAX_BEATS=1 instance alternates a and c
        req1 = 4'b0101; out_ready1 = 1'b1;
        q1.push_back('{4'b0001, WA});
        q1.push_back('{4'b0100, WC});
        q1.push_back('{4'b0001, WA});
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("s6_grant%0d", i), 32'(grant1), 32'(exp6[i]));
        end
        req1 = '0; out_ready1 = 1'b0;

        repeat (3) tick();
        chk("sb_drained", 32'(q.size() + q1.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux4way16_arbiter.md
MUX4WAY16_ARBITER -- requirements
Module: mux4way16_arbiter

Interface
REQ-001 SHALL have parameter MAX_BEATS, default 4: maximum transfers per grant before forced release; legal range 1..15.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port req, input, 4: per-requester request; bit i is requester i (0=a, 1=b, 2=c, 3=d).
REQ-005 SHALL have port last, input, 4: per-requester final-beat flag; sampled only for the current owner.
REQ-006 SHALL have ports a, b, c, d, each input, 16: requester data words.
REQ-007 SHALL have port out, output, 16: shared data path, equal to the owner's data word.
REQ-008 SHALL have port out_valid, output, 1: out carries a valid beat.
REQ-009 SHALL have port out_ready, input, 1: consumer accepts the beat.
REQ-010 SHALL have port grant, output, 4: one-hot current owner; all-zero when no owner.
REQ-011 SHALL have port sel, output, 2: registered owner index driving the shared mux.

Function
REQ-012 SHALL implement a two-state FSM: IDLE (no owner) and BUSY (owner held).
REQ-013 In IDLE with req != 0, SHALL select the first set bit in round-robin order starting at index ptr, register it into sel and grant, load beat count 0, and enter BUSY on the same edge.
- Grant latency: one clock from req sampled high to grant asserted.
REQ-014 In IDLE with req == 0, SHALL stay in IDLE with grant = 0 and sel unchanged.
REQ-015 In BUSY: out_valid = req[sel] (combinational); otherwise 0.
REQ-016 out SHALL equal the a/b/c/d word selected by sel at all times, including IDLE.
REQ-017 A transfer SHALL occur on any edge where out_valid and out_ready are both 1; the beat count then increments by 1 (4-bit counter).
REQ-018 SHALL release on a transfer edge when last[sel] = 1 or the post-increment count equals MAX_BEATS.
REQ-019 SHALL release on any BUSY edge where req[sel] = 0 (requester abandons); no transfer occurs on that edge.
REQ-020 On release: ptr <= (sel + 1) mod 4, grant <= 0, enter IDLE.
- Exactly one bubble cycle between consecutive grants.
- ptr wraps from 3 to 0.
REQ-021 With out_ready held 0 in BUSY, SHALL hold the owner indefinitely; there is no timeout.
REQ-022 Changes on non-owner req bits during BUSY SHALL have no effect until the next IDLE.
REQ-023 grant SHALL always be one-hot or zero, and SHALL be nonzero exactly when in BUSY.
REQ-024 Fairness: a requester holding req continuously SHALL be granted within 3 other grants.

Reset
REQ-025 Asserting rst_n low SHALL immediately force the following, independent of clk:
- state = IDLE, grant = 0, sel = 0, ptr = 0, beat count = 0;
- hence out_valid = 0 and out = a.
REQ-026 Reset mid-transfer SHALL abandon the burst; no beat is completed during reset.
REQ-027 The first arbitration after rst_n deasserts SHALL start at index 0.

Structure
REQ-028 State encodings (IDLE=0, BUSY=1) and requester index constants SHALL live in the shared arbiter definitions file, not local to the module.
REQ-029 SHALL instantiate exactly one Mux4Way16 for the a/b/c/d to out datapath, driven by sel.
REQ-030 The round-robin priority pick SHALL be a combinational function of req and ptr.

Verification
REQ-031 Reset then req=4'b0010, out_ready=1, last=0 -> grant=4'b0010 one clock later, out=b; 4 transfers, then release, ptr=2.
REQ-032 req=4'b1111 held, last=4'b1111, out_ready=1 -> grants cycle 0001, 0010, 0100, 1000, 0001, with one IDLE cycle between each.
REQ-033 Owner c, out_ready=0 for 20 cycles -> grant stays 4'b0100, out_valid=1, beat count stays 0.
REQ-034 Owner d after 2 beats, req[3] dropped -> IDLE next edge, ptr=0, no extra transfer counted.
REQ-035 rst_n pulsed low mid-burst (owner a, count 2) -> grant=0 and out_valid=0 asynchronously; next grant after reset taken from index 0.
REQ-036 MAX_BEATS=1, req=4'b0101 held -> grants alternate between a and c on every transfer.
